// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
// Bundles the instruction-memory request/response channel and the
// instruction hand-off channel toward decode. The master modport is the
// fetch unit's view. The slave modport is the view of the memory and
// decode side.
interface pc_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program counter and instruction-fetch sequencer for the NPC core.
// The unit keeps one instruction-memory request outstanding at a time.
// It hands each fetched word and its PC to decode over a valid/ready
// handshake. At retire, it uses decode's PCSel and execute's target to
// form the next PC.
//
// Optional build macro: PC_FETCH_RSP_BYPASS_EN
//   When this macro is defined, a memory response is forwarded
//   combinationally to decode in the same cycle it arrives. If decode
//   retires in that same cycle, the unit skips the hold state.
//   When the macro is undefined, all downstream outputs come from
//   registers.
module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCSel,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic                  misalign_err,
    pc_fetch_unit_if.master       bus
);

    // S_REQ  : a request is presented and held until memory accepts it
    // S_WAIT : waiting for the single outstanding response
    // S_HOLD : an instruction is being offered to decode
    // S_ERR  : a misaligned redirect was seen; the unit parks until reset
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [DATA_WIDTH-1:0] inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q;
    logic [ADDR_WIDTH-1:0] inst_pc_d;
    logic                  inst_valid_q;
    logic                  inst_valid_d;
    logic                  err_q;
    logic                  err_d;

    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  target_misaligned;
    logic                  rsp_bypass;
    logic                  retire;

    // Form the next PC. Bit 0 of a redirect is always dropped.
    // The sequential add wraps silently at the top of the address space.
    assign next_pc           = PCSel ? {target[ADDR_WIDTH-1:1], 1'b0} : pc_q + PC_STEP;
    assign target_misaligned = PCSel & target[1];

`ifdef PC_FETCH_RSP_BYPASS_EN
    assign rsp_bypass = (state_q == S_WAIT) && bus.imem_rsp_valid;
`else
    assign rsp_bypass = 1'b0;
`endif

    // Decode retires either the held instruction or a bypassed response.
    assign retire = ((state_q == S_HOLD) || rsp_bypass) && bus.inst_ready;

    // Compute the next state. Each field defaults to holding its value.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        err_d        = err_q;

        case (state_q)
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    inst_d       = bus.imem_rsp_data;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid_d = 1'b1;
            end
            S_ERR: begin
                inst_valid_d = 1'b0;
                err_d        = 1'b1;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        if (retire) begin
            inst_valid_d = 1'b0;
            if (target_misaligned) begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end else begin
                pc_d    = next_pc;
                state_d = S_REQ;
            end
        end
    end

    // State registers. Reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            err_q        <= err_d;
        end
    end

    // Drive the request side. The request is held low while reset is asserted.
    always_comb begin
        bus.imem_req_valid = rst_n && (state_q == S_REQ);
        bus.imem_req_addr  = pc_q;
        misalign_err       = err_q;
    end

    // Drive the decode side. With bypass enabled, a response that arrives
    // this cycle takes priority.
    always_comb begin
        bus.inst_valid = inst_valid_q | rsp_bypass;
        bus.inst       = rsp_bypass ? bus.imem_rsp_data : inst_q;
        bus.inst_pc    = rsp_bypass ? pc_q : inst_pc_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit in its default build.
// Each response the bench drives pushes its expected {inst, inst_pc} pair
// onto a scoreboard queue. The pair is popped and compared when decode
// sees the instruction.
module tb_pc_fetch_unit;

    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCSel = 1'b0;
    logic [31:0] target = '0;
    logic        misalign_err;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          req_count = 0;
    logic [31:0] model_pc = RESET_PC;
    logic [63:0] scb[$];

    pc_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pc_fetch_unit #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCSel       (PCSel),
        .target      (target),
        .misalign_err(misalign_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Count accepted requests so the bench can check one request per instruction.
    always @(posedge clk) begin
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) req_count <= req_count + 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drive one full fetch: request (with optional stall), zero-wait response,
    // and retire (with optional decode stall). Outputs are sampled at negedges.
    task automatic do_fetch(input int req_stall, input int hold_stall, input logic sel,
                            input logic [31:0] tgt, input logic [31:0] data,
                            output logic [31:0] got_addr, output logic got_stable,
                            output logic [31:0] got_inst, output logic [31:0] got_pc,
                            output logic timed_out);
        int n;
        got_stable = 1'b1;
        timed_out  = 1'b0;
        got_addr   = '0;
        got_inst   = '0;
        got_pc     = '0;
        n = 0;
        while (!bus.imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.imem_req_valid) begin
            timed_out = 1'b1;
            return;
        end
        got_addr = bus.imem_req_addr;
        for (int i = 0; i < req_stall; i++) begin
            bus.imem_req_ready = 1'b0;
            @(negedge clk);
            if (!bus.imem_req_valid || bus.imem_req_addr !== got_addr) got_stable = 1'b0;
        end
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        scb.push_back({data, model_pc});
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        n = 0;
        while (!bus.inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.inst_valid) begin
            timed_out = 1'b1;
            return;
        end
        got_inst = bus.inst;
        got_pc   = bus.inst_pc;
        for (int i = 0; i < hold_stall; i++) begin
            @(negedge clk);
            if (!bus.inst_valid || bus.inst !== got_inst || bus.inst_pc !== got_pc) got_stable = 1'b0;
        end
        bus.inst_ready = 1'b1;
        PCSel          = sel;
        target         = tgt;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        PCSel          = 1'b0;
        target         = $urandom;
        if (!(sel && tgt[1])) model_pc = sel ? {tgt[31:1], 1'b0} : model_pc + 32'd4;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valids: req_valid=%b inst_valid=%b, want 0/0", bus.imem_req_valid, bus.inst_valid);
        end
        tests_run++;
        if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs: inst=%h inst_pc=%h err=%b, want 0/0/0", bus.inst, bus.inst_pc, misalign_err);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_req: valid=%b addr=%h, want 1/%h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
        end
        model_pc = RESET_PC;
    endtask

    task automatic test_sequential();
        logic [31:0] a, i, p;
        logic        st, to;
        logic [63:0] e;
        do_fetch(0, 0, 1'b0, 32'h0, 32'h0000_0013, a, st, i, p, to);
        tests_run++;
        if (to !== 1'b0 || a !== 32'h8000_0000) begin
            tests_failed++;
            $display("[TB] FAIL seq_addr: addr=%h timeout=%b, want 80000000/0", a, to);
        end
        e = (scb.size() > 0) ? scb.pop_front() : 64'hx;
        tests_run++;
        if (i !== e[63:32] || p !== e[31:0]) begin
            tests_failed++;
            $display("[TB] FAIL seq_inst: inst=%h pc=%h, want %h/%h", i, p, e[63:32], e[31:0]);
        end
        tests_run++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0004) begin
            tests_failed++;
            $display("[TB] FAIL seq_next_req: valid=%b addr=%h, want 1/80000004", bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a, i, p;
        logic        st, to;
        logic [63:0] e;
        do_fetch(0, 0, 1'b1, 32'h8000_0101, 32'h0000_0063, a, st, i, p, to);
        e = (scb.size() > 0) ? scb.pop_front() : 64'hx;
        tests_run++;
        if (to !== 1'b0 || i !== e[63:32] || p !== e[31:0]) begin
            tests_failed++;
            $display("[TB] FAIL branch_inst: inst=%h pc=%h timeout=%b, want %h/%h/0", i, p, to, e[63:32], e[31:0]);
        end
        tests_run++;
        if (bus.imem_req_addr !== 32'h8000_0100 || bus.imem_req_valid !== 1'b1 || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL branch_target: addr=%h valid=%b err=%b, want 80000100/1/0", bus.imem_req_addr, bus.imem_req_valid, misalign_err);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, i, p;
        logic        st, to;
        logic [63:0] e;
        int          c0;
        c0 = req_count;
        do_fetch(5, 3, 1'b0, 32'h0, 32'hCAFE_0B07, a, st, i, p, to);
        tests_run++;
        if (st !== 1'b1 || to !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_stable: stable=%b timeout=%b, want 1/0", st, to);
        end
        e = (scb.size() > 0) ? scb.pop_front() : 64'hx;
        tests_run++;
        if (i !== e[63:32] || p !== e[31:0] || a !== 32'h8000_0100) begin
            tests_failed++;
            $display("[TB] FAIL stall_inst: inst=%h pc=%h addr=%h, want %h/%h/80000100", i, p, a, e[63:32], e[31:0]);
        end
        tests_run++;
        if (req_count - c0 !== 1 || bus.imem_req_addr !== 32'h8000_0104) begin
            tests_failed++;
            $display("[TB] FAIL stall_one_req: requests=%0d next=%h, want 1/80000104", req_count - c0, bus.imem_req_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a, i, p;
        logic        st, to;
        logic [63:0] e;
        do_fetch(0, 0, 1'b1, 32'hFFFF_FFFC, 32'h1111_1111, a, st, i, p, to);
        void'(scb.pop_front());
        do_fetch(0, 0, 1'b0, 32'h0, 32'h2222_2222, a, st, i, p, to);
        e = (scb.size() > 0) ? scb.pop_front() : 64'hx;
        tests_run++;
        if (a !== 32'hFFFF_FFFC || i !== e[63:32] || p !== e[31:0]) begin
            tests_failed++;
            $display("[TB] FAIL wrap_top: addr=%h inst=%h pc=%h, want fffffffc/%h/%h", a, i, p, e[63:32], e[31:0]);
        end
        tests_run++;
        if (bus.imem_req_addr !== 32'h0000_0000 || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_addr: addr=%h err=%b, want 00000000/0", bus.imem_req_addr, misalign_err);
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h2222_2222 || bus.imem_req_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL spurious_rsp: inst_valid=%b inst=%h req_valid=%b, want 0/22222222/1", bus.inst_valid, bus.inst, bus.imem_req_valid);
        end
        do_fetch(0, 0, 1'b0, 32'h0, 32'h3333_3333, a, st, i, p, to);
        e = (scb.size() > 0) ? scb.pop_front() : 64'hx;
        tests_run++;
        if (i !== e[63:32] || p !== e[31:0] || p !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_fetch: inst=%h pc=%h, want %h/%h", i, p, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] a, i, p;
        logic        st, to, quiet;
        logic [63:0] e;
        do_fetch(0, 0, 1'b1, 32'h8000_0102, 32'h4444_4444, a, st, i, p, to);
        e = (scb.size() > 0) ? scb.pop_front() : 64'hx;
        tests_run++;
        if (to !== 1'b0 || i !== e[63:32] || p !== e[31:0]) begin
            tests_failed++;
            $display("[TB] FAIL misalign_inst: inst=%h pc=%h, want %h/%h", i, p, e[63:32], e[31:0]);
        end
        tests_run++;
        if (misalign_err !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL misalign_flag: err=%b req_valid=%b inst_valid=%b, want 1/0/0", misalign_err, bus.imem_req_valid, bus.inst_valid);
        end
        quiet = 1'b1;
        bus.imem_req_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.imem_rsp_valid = k[0];
            bus.imem_rsp_data  = $urandom;
            bus.inst_ready     = 1'b1;
            @(negedge clk);
            if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || misalign_err !== 1'b1) quiet = 1'b0;
        end
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        tests_run++;
        if (quiet !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL misalign_sticky: quiet=%b, want 1", quiet);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        model_pc = RESET_PC;
        scb.delete();
        tests_run++;
        if (misalign_err !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
            tests_failed++;
            $display("[TB] FAIL misalign_recover: err=%b valid=%b addr=%h, want 0/1/%h", misalign_err, bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, i, p;
        logic        st, to, quiet;
        logic [63:0] e;
        @(negedge clk);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h5555_AAAA;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        model_pc = RESET_PC;
        scb.delete();
        quiet = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0) quiet = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (quiet !== 1'b1 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_ignore: quiet=%b req_valid=%b addr=%h, want 1/1/%h", quiet, bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
        end
        do_fetch(0, 0, 1'b0, 32'h0, 32'h6666_0001, a, st, i, p, to);
        e = (scb.size() > 0) ? scb.pop_front() : 64'hx;
        tests_run++;
        if (to !== 1'b0 || i !== e[63:32] || p !== e[31:0] || p !== RESET_PC) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_fetch: inst=%h pc=%h, want %h/%h", i, p, e[63:32], e[31:0]);
        end
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the NPC core.
- Sits upstream of decode/execute and consumes that stage's branch-comparator PCSel and the execute-computed jump/branch target to form the next PC.
- Issues one outstanding request at a time on a valid/ready instruction-memory interface.
- Presents the fetched instruction and its PC downstream with a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- PCSel  input  1  1 = take target, 0 = sequential; sampled only at retire.
- target  input  ADDR_WIDTH  redirect address from execute.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  ADDR_WIDTH  fetch address (= PC).
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  DATA_WIDTH  fetched instruction.
- inst_valid  output  1  inst/inst_pc valid to decode.
- inst_ready  input  1  downstream retires current instruction.
- inst  output  DATA_WIDTH  instruction word.
- inst_pc  output  ADDR_WIDTH  PC of inst.
- misalign_err  output  1  sticky misaligned-target flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; state = S_REQ.
  - inst = 0, inst_pc = 0, inst_valid = 0, misalign_err = 0.
  - imem_req_valid goes high from the first cycle after deassertion.
  - Reset mid-transaction aborts it; any late response is ignored, because the unit is in S_REQ.
- States:
  - S_REQ: imem_req_valid = 1, imem_req_addr = pc.
    - On imem_req_valid & imem_req_ready -> S_WAIT.
    - Otherwise hold; address stays stable until accepted.
  - S_WAIT: imem_req_valid = 0.
    - On imem_rsp_valid: inst <= imem_rsp_data, inst_pc <= pc, inst_valid <= 1, -> S_HOLD.
  - S_HOLD: inst_valid = 1; inst and inst_pc stable.
    - On inst_ready: compute next_pc.
    - If aligned: pc <= next_pc, inst_valid <= 0, -> S_REQ.
  - S_ERR: terminal until reset.
    - imem_req_valid = 0, inst_valid = 0, misalign_err = 1.
- next_pc:
  - PCSel ? {target[ADDR_WIDTH-1:1], 1'b0} : pc + 4.
  - Addition is modulo 2^ADDR_WIDTH: 32'hFFFF_FFFC + 4 = 0, no flag.
- Misalignment:
  - Applies when PCSel = 1 and target[1] = 1 at retire.
  - Result: misalign_err <= 1, pc unchanged, -> S_ERR.
  - target[0] is always cleared, never an error.
- imem_rsp_valid outside S_WAIT is ignored.
- PCSel and target are don't-care outside S_HOLD & inst_ready.
- Latency:
  - Request acceptance to inst_valid: 1 cycle after rsp_valid.
  - Retire to next imem_req_valid: 1 cycle.
  - Zero-wait memory gives one instruction every 3 cycles.

Optional Feature:
- Macro PC_FETCH_RSP_BYPASS_EN.
- Defined:
  - In S_WAIT with imem_rsp_valid, inst_valid = 1 combinationally, inst = imem_rsp_data, inst_pc = pc in the same cycle.
  - If inst_ready is also high that cycle, next_pc is applied and the unit goes directly to S_REQ, skipping S_HOLD.
  - Otherwise the data is registered and the unit enters S_HOLD as normal.
  - Zero-wait throughput becomes 1 instruction per 2 cycles.
- Undefined: fully registered outputs as described in Behaviour.

Test Plan:
- Reset release, req_ready = 1, rsp one cycle later with 32'h0000_0013, inst_ready = 1 -> first request addr 8000_0000; inst_valid with inst = 0000_0013, inst_pc = 8000_0000; next request addr 8000_0004.
- Retire with PCSel = 1, target = 8000_0101 -> next request addr 8000_0100; misalign_err = 0.
- Retire with PCSel = 1, target = 8000_0102 -> misalign_err = 1; no further imem_req_valid; inst_valid = 0 until rst_n pulse; after reset, request addr 8000_0000 again.
- req_ready low 5 cycles, then inst_ready low 3 cycles after inst_valid -> imem_req_addr stable through the stall; inst and inst_pc stable; exactly one request per instruction.
- pc = FFFF_FFFC with sequential retire -> next request addr 0000_0000; spurious rsp_valid in S_REQ does not change inst.
- rst_n asserted while in S_WAIT, rsp_valid arrives the cycle after deassert -> response ignored; new request to 8000_0000 issued; inst_valid stays 0 until its own response.
